// File: rtl/calc_sequencer.sv
// Calculation sequencer: re-arm peripherals, load operands, launch adder, latch result, show it.
// Latency: newop->PRST 3 cycles, inputdata_ready->alu_start 1 edge, alu_done->dataR 1 cycle.
// Backpressure: none; newop edges outside SHOW are dropped. Watchdog built under CALC_SEQ_TIMEOUT_EN.
module calc_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        newop,
    input  logic        inputdata_ready,
    input  logic        alu_done,
    input  logic [31:0] alu_result,
    output logic        loaddata,
    output logic        periph_rst,
    output logic        alu_start,
    output logic [31:0] dataR,
    output logic        busy,
    output logic        err,
    output logic [7:0]  op_count
);

    typedef enum logic [2:0] {
        S_PRST  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_SHOW  = 3'd4
    } state_t;

    localparam logic [31:0] ERR_PATTERN = 32'hEEEE_EEEE;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("calc_sequencer: TIMEOUT_CYCLES must be in 2..65535");
    end

    state_t      r_state;
    state_t      w_next;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic        w_newop_edge;
    logic        w_done_take;
    logic        w_timeout;
    logic [31:0] r_data;
    logic [7:0]  r_op_count;

    // Button: two-flop synchronizer, then rising-edge detect on the synchronized level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= newop;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_newop_edge = r_sync2 & ~r_prev;
    assign w_done_take  = (r_state == S_WAIT) & alu_done;

`ifdef CALC_SEQ_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wd_cnt;
    logic        r_err;

    // Held at zero outside WAIT so every WAIT entry starts from a clean count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd_cnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_state == S_WAIT) && !alu_done && (r_wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_done_take) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if ((r_state == S_SHOW) && w_newop_edge) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_PRST;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_PRST:  w_next = S_LOAD;
            S_LOAD:  if (inputdata_ready) w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT:  if (alu_done || w_timeout) w_next = S_SHOW;
            S_SHOW:  if (w_newop_edge) w_next = S_PRST;
            default: w_next = S_PRST;
        endcase
    end

    // Done takes priority over a coincident watchdog expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data     <= '0;
            r_op_count <= '0;
        end else if (w_done_take) begin
            r_data     <= alu_result;
            r_op_count <= r_op_count + 8'd1;
        end else if (w_timeout) begin
            r_data     <= ERR_PATTERN;
            r_op_count <= r_op_count + 8'd1;
        end
    end

    assign periph_rst = (r_state == S_PRST);
    assign alu_start  = (r_state == S_START);
    assign loaddata   = (r_state != S_SHOW);
    assign busy       = (r_state != S_SHOW);
    assign dataR      = r_data;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_calc_sequencer.sv
// Randomized scoreboard bench for calc_sequencer; results checked on each entry into SHOW.
module tb_calc_sequencer;

    logic        clk;
    logic        reset;
    logic        newop;
    logic        inputdata_ready;
    logic        alu_done;
    logic [31:0] alu_result;
    logic        loaddata;
    logic        periph_rst;
    logic        alu_start;
    logic [31:0] dataR;
    logic        busy;
    logic        err;
    logic [7:0]  op_count;

    calc_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .newop           (newop),
        .inputdata_ready (inputdata_ready),
        .alu_done        (alu_done),
        .alu_result      (alu_result),
        .loaddata        (loaddata),
        .periph_rst      (periph_rst),
        .alu_start       (alu_start),
        .dataR           (dataR),
        .busy            (busy),
        .err             (err),
        .op_count        (op_count)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   model_ops = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference model: completed operations counted mod 256.
    task automatic push_expect(input logic [31:0] data, input logic e);
        exp_t x;
        model_ops = (model_ops + 1) % 256;
        x.data = data;
        x.err  = e;
        x.cnt  = 8'(model_ops);
        sb_q.push_back(x);
    endtask

    // Monitor: every busy fall (entry into SHOW) consumes one expected result.
    initial begin
        logic prev_busy;
        exp_t e;
        prev_busy = 1'b1;
        forever begin
            @(negedge clk);
            if (reset && prev_busy && !busy) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_show: got dataR=%h with no expected result", dataR);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_dataR", dataR, e.data);
                    check("sb_err", {31'd0, err}, {31'd0, e.err});
                    check("sb_op_count", {24'd0, op_count}, {24'd0, e.cnt});
                    check("sb_loaddata", {31'd0, loaddata}, 32'd0);
                end
            end
            prev_busy = busy;
        end
    end

    // From a LOAD cycle: raise inputdata_ready, expect START next, then WAIT.
    task automatic launch(input bit glitch);
        inputdata_ready = 1'b1;
        tick();
        check("start_pulse", {31'd0, alu_start}, 32'd1);
        inputdata_ready = 1'b0;
        if (glitch) begin
            alu_done   = 1'b1;
            alu_result = 32'hDEAD_BEEF;
        end
        tick();
        alu_done = 1'b0;
        check("start_width", {31'd0, alu_start}, 32'd0);
        check("wait_busy", {31'd0, busy}, 32'd1);
        check("wait_loaddata", {31'd0, loaddata}, 32'd1);
    endtask

    task automatic drive_done(input logic [31:0] res);
        alu_done   = 1'b1;
        alu_result = res;
        push_expect(res, 1'b0);
        tick();
        alu_done   = 1'b0;
        alu_result = $urandom;
        check("show_busy", {31'd0, busy}, 32'd0);
    endtask

    // From SHOW: press newop for `hold` cycles; expect one PRST pulse exactly 3 cycles later.
    task automatic press(input int hold);
        int pulses;
        int pos;
        pulses = 0;
        pos    = 0;
        newop  = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == hold) newop = 1'b0;
            if (periph_rst) begin
                pulses++;
                if (pos == 0) pos = k;
            end
        end
        newop = 1'b0;
        check("prst_pulses", 32'(pulses), 32'd1);
        check("prst_latency", 32'(pos), 32'd3);
        check("op_count_kept", {24'd0, op_count}, 32'(model_ops));
        check("err_after_newop", {31'd0, err}, 32'd0);
        check("load_after_prst", {31'd0, loaddata & busy}, 32'd1);
    endtask

    initial begin
        reset           = 1'b0;
        newop           = 1'b0;
        inputdata_ready = 1'b0;
        alu_done        = 1'b0;
        alu_result      = '0;
        repeat (3) tick();
        check("rst_periph_rst", {31'd0, periph_rst}, 32'd1);
        check("rst_loaddata", {31'd0, loaddata}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_alu_start", {31'd0, alu_start}, 32'd0);
        check("rst_dataR", dataR, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_op_count", {24'd0, op_count}, 32'd0);

        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        check("first_cycle_prst", {31'd0, periph_rst}, 32'd1);
        tick();
        check("prst_one_cycle", {31'd0, periph_rst}, 32'd0);
        check("load_loaddata", {31'd0, loaddata}, 32'd1);
        check("load_busy", {31'd0, busy}, 32'd1);
        repeat (2) tick();
        check("load_holds", {31'd0, alu_start | periph_rst}, 32'd0);
        check("load_dataR", dataR, 32'd0);
        check("load_op_count", {24'd0, op_count}, 32'd0);

        // First operation; a newop pulse during WAIT must be discarded.
        launch(1'b0);
        newop = 1'b1;
        tick();
        newop = 1'b0;
        repeat (3) tick();
        drive_done(32'h1234_5678);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("show_not_queued", {31'd0, busy}, 32'd0);
        end
        press(10);

        // alu_done in START is ignored.
        launch(1'b1);
        repeat (2) tick();
        drive_done($urandom);
        press(1);

`ifdef CALC_SEQ_TIMEOUT_EN
        launch(1'b0);
        repeat (7) tick();
        check("wd_still_wait", {31'd0, busy}, 32'd1);
        push_expect(32'hEEEE_EEEE, 1'b1);
        tick();
        check("wd_show", {31'd0, busy}, 32'd0);
        tick();
        check("wd_err_held", {31'd0, err}, 32'd1);
        press(1);
`else
        launch(1'b0);
        repeat (100) tick();
        check("nowd_still_wait", {31'd0, busy}, 32'd1);
        check("nowd_err", {31'd0, err}, 32'd0);
        drive_done($urandom);
        press(1);
`endif

        // Done on the watchdog's final cycle wins.
        launch(1'b0);
        repeat (7) tick();
        drive_done($urandom);
        press(1);

        // Reset mid-WAIT: immediate PRST values, in-flight result dropped.
        launch(1'b0);
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check("midrst_periph_rst", {31'd0, periph_rst}, 32'd1);
        check("midrst_busy", {31'd0, busy & loaddata}, 32'd1);
        check("midrst_alu_start", {31'd0, alu_start}, 32'd0);
        check("midrst_dataR", dataR, 32'd0);
        check("midrst_op_count", {24'd0, op_count}, 32'd0);
        model_ops  = 0;
        alu_done   = 1'b1;
        alu_result = 32'hCAFE_F00D;
        tick();
        alu_done   = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) tick();
        check("postrst_dataR", dataR, 32'd0);
        check("postrst_load", {31'd0, busy & ~periph_rst}, 32'd1);

        for (int i = 0; i < 256; i++) begin
            launch(1'b0);
            repeat ($urandom_range(0, 6)) tick();
            drive_done($urandom);
            press(1);
        end
        check("wrap_op_count", {24'd0, op_count}, 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
